// File: rtl/pwm_pkg.sv
// Shared register map, FSM state encoding and byte-enable helper for the PWM dead-band stage.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [7:0] ADR_DB_CTRL_1      = 8'h00;
    localparam logic [7:0] ADR_DB_DEAD_RISE_1 = 8'h04;
    localparam logic [7:0] ADR_DB_DEAD_FALL_1 = 8'h08;
    localparam logic [7:0] ADR_DB_STATUS_1    = 8'h0C;
    localparam logic [7:0] ADR_DB_CTRL_2      = 8'h10;
    localparam logic [7:0] ADR_DB_DEAD_RISE_2 = 8'h14;
    localparam logic [7:0] ADR_DB_DEAD_FALL_2 = 8'h18;
    localparam logic [7:0] ADR_DB_STATUS_2    = 8'h1C;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_DEAD = 2'd2,
        ST_HIGH = 2'd3
    } db_state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) r[8*n +: 8] = new_v[8*n +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_deadband_chan.sv
// One channel: input sync register, break-before-make FSM with dead-time counter, output inversion.
// Latency: pwm change sampled at edge k moves the drives at edge k+1; free-running, no backpressure.
module pwm_deadband_chan
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pwm,
    input  logic             en,
    input  logic             inv_h,
    input  logic             inv_l,
    input  logic [CNT_W-1:0] dead_rise,
    input  logic [CNT_W-1:0] dead_fall,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic [1:0]       fsm_state,
    output logic             pwm_q
);

    db_state_e        state;
    logic             rising;
    logic [CNT_W-1:0] cnt;
    logic             raw_h;
    logic             raw_l;

    // Raw drives are registered alongside the state they belong to, so they
    // can never both be high: HIGH and LOW are distinct states.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_q  <= 1'b0;
            state  <= ST_OFF;
            rising <= 1'b0;
            cnt    <= '0;
            raw_h  <= 1'b0;
            raw_l  <= 1'b0;
        end else begin
            pwm_q <= pwm;
            if (!en) begin
                state <= ST_OFF;
                cnt   <= '0;
                raw_h <= 1'b0;
                raw_l <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (!pwm_q) begin
                            state <= ST_LOW;
                            raw_l <= 1'b1;
                        end else if (dead_rise == '0) begin
                            state <= ST_HIGH;
                            raw_h <= 1'b1;
                        end else begin
                            state  <= ST_DEAD;
                            rising <= 1'b1;
                            cnt    <= dead_rise - 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (pwm_q) begin
                            raw_l <= 1'b0;
                            if (dead_rise == '0) begin
                                state <= ST_HIGH;
                                raw_h <= 1'b1;
                            end else begin
                                state  <= ST_DEAD;
                                rising <= 1'b1;
                                cnt    <= dead_rise - 1'b1;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (!pwm_q) begin
                            raw_h <= 1'b0;
                            if (dead_fall == '0) begin
                                state <= ST_LOW;
                                raw_l <= 1'b1;
                            end else begin
                                state  <= ST_DEAD;
                                rising <= 1'b0;
                                cnt    <= dead_fall - 1'b1;
                            end
                        end
                    end
                    ST_DEAD: begin
                        // Input reverted before the gap elapsed: fall back to the side we came from.
                        if (pwm_q != rising) begin
                            state <= rising ? ST_LOW : ST_HIGH;
                            raw_l <= rising;
                            raw_h <= !rising;
                        end else if (cnt == '0) begin
                            state <= rising ? ST_HIGH : ST_LOW;
                            raw_h <= rising;
                            raw_l <= !rising;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end
    end

    assign pwm_h     = raw_h ^ inv_h;
    assign pwm_l     = raw_l ^ inv_l;
    assign fsm_state = state;

endmodule

// File: rtl/pwm_deadband.sv
// Complementary high/low-side driver pair per PWM channel with programmable dead time and a register window.
// Latency: one cycle from pwm input sample to drive change; register access is single-cycle, no backpressure.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    input  logic        pwm1_i,
    input  logic        pwm2_i,
    output logic        pwm1_h_o,
    output logic        pwm1_l_o,
    output logic        pwm2_h_o,
    output logic        pwm2_l_o
);

    logic [2:0]       ctrl1, ctrl2;
    logic [CNT_W-1:0] rise1, fall1, rise2, fall2;
    logic [1:0]       st1, st2;
    logic             q1, q2;
    logic             wr_en;

    assign wr_en = we_i & ~re_i;

    // The read mux already presents the addressed register, so it doubles as
    // the old value for byte-enable merging.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl1 <= '0;
            ctrl2 <= '0;
            rise1 <= '0;
            fall1 <= '0;
            rise2 <= '0;
            fall2 <= '0;
        end else if (wr_en) begin
            case (addr_i)
                ADR_DB_CTRL_1:      ctrl1 <= 3'(be_merge(rdata_o, wdata_i, be_i));
                ADR_DB_DEAD_RISE_1: rise1 <= CNT_W'(be_merge(rdata_o, wdata_i, be_i));
                ADR_DB_DEAD_FALL_1: fall1 <= CNT_W'(be_merge(rdata_o, wdata_i, be_i));
                ADR_DB_CTRL_2:      ctrl2 <= 3'(be_merge(rdata_o, wdata_i, be_i));
                ADR_DB_DEAD_RISE_2: rise2 <= CNT_W'(be_merge(rdata_o, wdata_i, be_i));
                ADR_DB_DEAD_FALL_2: fall2 <= CNT_W'(be_merge(rdata_o, wdata_i, be_i));
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            ADR_DB_CTRL_1:      rdata_o = 32'(ctrl1);
            ADR_DB_DEAD_RISE_1: rdata_o = 32'(rise1);
            ADR_DB_DEAD_FALL_1: rdata_o = 32'(fall1);
            ADR_DB_STATUS_1:    rdata_o = {29'd0, q1, st1};
            ADR_DB_CTRL_2:      rdata_o = 32'(ctrl2);
            ADR_DB_DEAD_RISE_2: rdata_o = 32'(rise2);
            ADR_DB_DEAD_FALL_2: rdata_o = 32'(fall2);
            ADR_DB_STATUS_2:    rdata_o = {29'd0, q2, st2};
            default:            rdata_o = '0;
        endcase
    end

    pwm_deadband_chan #(.CNT_W(CNT_W)) u_ch1 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pwm       (pwm1_i),
        .en        (ctrl1[0]),
        .inv_h     (ctrl1[1]),
        .inv_l     (ctrl1[2]),
        .dead_rise (rise1),
        .dead_fall (fall1),
        .pwm_h     (pwm1_h_o),
        .pwm_l     (pwm1_l_o),
        .fsm_state (st1),
        .pwm_q     (q1)
    );

    pwm_deadband_chan #(.CNT_W(CNT_W)) u_ch2 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pwm       (pwm2_i),
        .en        (ctrl2[0]),
        .inv_h     (ctrl2[1]),
        .inv_l     (ctrl2[2]),
        .dead_rise (rise2),
        .dead_fall (fall2),
        .pwm_h     (pwm2_h_o),
        .pwm_l     (pwm2_l_o),
        .fsm_state (st2),
        .pwm_q     (q2)
    );

endmodule
